// File: rtl/btn_pkg.sv
// Shared definitions for the button scan/debounce controller.
// Holds the default bank size and debounce threshold, plus the event record
// (press/release flag and button index) exchanged with event consumers.
package btn_pkg;

    localparam int BTN_N_DEFAULT         = 4;
    localparam int BTN_THRESHOLD_DEFAULT = 16;

    // Event index field is sized for the largest bank this block is used with;
    // consumers take the low IDX_W bits.
    localparam int BTN_IDX_W_MAX = 8;

    typedef struct packed {
        logic                     press;  // 1 = press (0->1), 0 = release (1->0)
        logic [BTN_IDX_W_MAX-1:0] idx;    // button that produced the event
    } btn_evt_t;

endpackage

// File: rtl/btn_sync2.sv
// Purpose : two-flop synchronizer for one asynchronous button pin.
// Latency : 2 clock cycles from pin to q.
// Backpr. : none; shifts every cycle regardless of enable or stall.
// Ports   : clock, reset (async active-high), d (async pin), q (synchronized level).
module btn_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_scan_ctrl.sv
// Purpose : time-multiplexed debounce of N_BTN buttons with one shared
//           compare/increment engine, plus a one-deep press/release event output.
// Latency : 2 sync + slot wait + (THRESHOLD-1)*N_BTN + 1 cycles from pin edge
//           to filtered/evt_valid (which rise together).
// Backpr. : while evt_valid & ~evt_ready the scan pointer, counters and levels
//           freeze; consume and a new commit on the same edge give no bubble.
// Ports   : clock, reset (async active-high), enable (scan enable),
//           raw_btn (async pins), filtered (debounced levels),
//           evt_valid/evt_ready/evt_press/evt_idx (event handshake),
//           scan_idx (slot serviced this cycle, debug).
module btn_scan_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN     = BTN_N_DEFAULT,
    parameter int THRESHOLD = BTN_THRESHOLD_DEFAULT,
    parameter int IDX_W     = $clog2(N_BTN),
    parameter int CNT_W     = $clog2(THRESHOLD + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_BTN-1:0] raw_btn,
    output logic [N_BTN-1:0] filtered,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_press,
    output logic [IDX_W-1:0] evt_idx,
    output logic [IDX_W-1:0] scan_idx
);

    localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(THRESHOLD);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_BTN - 1);

    // ------------------------------------------------------------------
    // Per-pin synchronizers
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] sync_btn;

    for (genvar g = 0; g < N_BTN; g++) begin : g_sync
        btn_sync2 u_sync (
            .clock (clock),
            .reset (reset),
            .d     (raw_btn[g]),
            .q     (sync_btn[g])
        );
    end

    // ------------------------------------------------------------------
    // Per-button state and shared engine
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] filtered_q;
    logic [N_BTN-1:0] filtered_d;
    logic [IDX_W-1:0] scan_idx_q;
    logic [IDX_W-1:0] scan_idx_d;
    logic             evt_valid_q;
    logic             evt_valid_d;
    logic             evt_press_q;
    logic             evt_press_d;
    logic [IDX_W-1:0] evt_idx_q;
    logic [IDX_W-1:0] evt_idx_d;

    logic             stall;
    logic             advance;
    logic             cur_sync;
    logic             cur_filt;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] cur_cnt_inc;

    always_comb begin
        cnt_d       = cnt_q;
        filtered_d  = filtered_q;
        scan_idx_d  = scan_idx_q;
        evt_valid_d = evt_valid_q;
        evt_press_d = evt_press_q;
        evt_idx_d   = evt_idx_q;

        // An unaccepted event holds the whole engine so that at most one
        // event is ever outstanding and none is lost.
        stall   = evt_valid_q & ~evt_ready;
        advance = enable & ~stall;

        cur_sync    = sync_btn[scan_idx_q];
        cur_filt    = filtered_q[scan_idx_q];
        cur_cnt     = cnt_q[scan_idx_q];
        cur_cnt_inc = cur_cnt + CNT_W'(1);

        if (evt_valid_q & evt_ready) begin
            evt_valid_d = 1'b0;
        end

        if (advance) begin
            if (cur_sync == cur_filt) begin
                // Any agreeing sample restarts the disagreement run.
                cnt_d[scan_idx_q] = '0;
            end else if (cur_cnt_inc == CNT_COMMIT) begin
                // Commit overrides a same-edge consume: back-to-back events.
                filtered_d[scan_idx_q] = cur_sync;
                cnt_d[scan_idx_q]      = '0;
                evt_valid_d            = 1'b1;
                evt_idx_d              = scan_idx_q;
                evt_press_d            = cur_sync;
            end else begin
                cnt_d[scan_idx_q] = cur_cnt_inc;
            end

            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            filtered_q  <= '0;
            scan_idx_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_press_q <= 1'b0;
            evt_idx_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            filtered_q  <= filtered_d;
            scan_idx_q  <= scan_idx_d;
            evt_valid_q <= evt_valid_d;
            evt_press_q <= evt_press_d;
            evt_idx_q   <= evt_idx_d;
        end
    end

    assign filtered  = filtered_q;
    assign evt_valid = evt_valid_q;
    assign evt_press = evt_press_q;
    assign evt_idx   = evt_idx_q;
    assign scan_idx  = scan_idx_q;

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Bench for btn_scan_ctrl (N_BTN=4, THRESHOLD=16): directed scenarios with
// inline checks plus randomized bouncing/backpressure, all shadowed by a
// cycle-level reference model of the debounce rules.
module tb_btn_scan_ctrl;
    import btn_pkg::*;

    localparam int N     = 4;
    localparam int TH    = 16;
    localparam int IW    = 2;
    localparam int OBS_W = N + 2 + 2 * IW;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [N-1:0]  raw_btn;
    logic [N-1:0]  filtered;
    logic          evt_valid;
    logic          evt_ready;
    logic          evt_press;
    logic [IW-1:0] evt_idx;
    logic [IW-1:0] scan_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    btn_scan_ctrl #(.N_BTN(N), .THRESHOLD(TH)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .raw_btn   (raw_btn),
        .filtered  (filtered),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_press (evt_press),
        .evt_idx   (evt_idx),
        .scan_idx  (scan_idx)
    );

    logic [OBS_W-1:0] dut_obs;
    assign dut_obs = {filtered, evt_valid, evt_press, evt_idx, scan_idx};

    // ------------------------------------------------------------------
    // Reference model: pin history two edges deep, run length of
    // disagreeing samples per button, committed level, round-robin slot
    // and the single pending event.
    // ------------------------------------------------------------------
    int       m_pin1 [N];
    int       m_pin2 [N];
    int       m_run  [N];
    int       m_lvl  [N];
    int       m_slot;
    bit       m_pend;
    btn_evt_t m_evt;

    always @(posedge clock or posedge reset) begin
        bit hold_all;
        int b;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_pin1[i] = 0; m_pin2[i] = 0; m_run[i] = 0; m_lvl[i] = 0;
            end
            m_slot = 0;
            m_pend = 0;
            m_evt  = '0;
        end else begin
            hold_all = m_pend && !evt_ready;
            if (m_pend && evt_ready) m_pend = 0;
            if (enable && !hold_all) begin
                b = m_slot;
                if (m_pin2[b] == m_lvl[b]) begin
                    m_run[b] = 0;
                end else begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == TH) begin
                        m_lvl[b]    = m_pin2[b];
                        m_run[b]    = 0;
                        m_pend      = 1;
                        m_evt.press = (m_pin2[b] != 0);
                        m_evt.idx   = BTN_IDX_W_MAX'(b);
                    end
                end
                m_slot = (m_slot + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                m_pin2[i] = m_pin1[i];
                m_pin1[i] = int'(raw_btn[i]);
            end
        end
    end

    function automatic logic [OBS_W-1:0] model_obs();
        logic [N-1:0] f;
        for (int i = 0; i < N; i++) f[i] = (m_lvl[i] != 0);
        return {f, m_pend, m_evt.press, IW'(m_evt.idx), IW'(m_slot)};
    endfunction

    // Lockstep scoreboard against the model, away from the active edge.
    always @(negedge clock) begin
        n_cmp++;
        if (dut_obs !== model_obs()) begin
            n_bad++;
            $display("FAIL lockstep t=%0t got={filt,vld,press,idx,scan}=%b expected=%b",
                     $time, dut_obs, model_obs());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic clear_all();
        raw_btn   = '0;
        enable    = 1'b1;
        evt_ready = 1'b1;
        repeat (90) @(negedge clock);
    endtask

    task automatic wait_slot(input int s);
        int k;
        k = 0;
        while (scan_idx !== IW'(s) && k < 16) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (scan_idx !== IW'(s)) begin
            n_bad++;
            $display("FAIL wait_slot got=%0d expected=%0d", scan_idx, s);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        bit all_low;
        reset = 1'b1; enable = 1'b1; evt_ready = 1'b1; raw_btn = '0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (dut_obs !== '0) begin
            n_bad++; $display("FAIL reset_state got=%b expected=0", dut_obs);
        end
        reset = 1'b0; raw_btn = '1;
        repeat (100) @(negedge clock);
        n_cmp++;
        if (filtered !== 4'b1111) begin
            n_bad++; $display("FAIL all_pressed got=%b expected=1111", filtered);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (dut_obs !== '0) begin
            n_bad++; $display("FAIL async_reset got=%b expected=0", dut_obs);
        end
        @(negedge clock);
        reset = 1'b0;
        all_low = 1'b1;
        for (int c = 0; c < 62; c++) begin
            @(negedge clock);
            if (filtered !== '0) all_low = 1'b0;
        end
        n_cmp++;
        if (!all_low) begin
            n_bad++; $display("FAIL post_reset_hold got=%b expected=0000", filtered);
        end
        repeat (6) @(negedge clock);
        n_cmp++;
        if (filtered !== 4'b1111) begin
            n_bad++; $display("FAIL post_reset_commit got=%b expected=1111", filtered);
        end
        clear_all();
    endtask

    task automatic test_steady_press();
        int c;
        raw_btn[2] = 1'b1;
        c = 0;
        while (evt_valid !== 1'b1 && c < 100) begin
            @(negedge clock);
            c++;
        end
        n_cmp++;
        if (evt_valid !== 1'b1 || c < 63 || c > 67) begin
            n_bad++; $display("FAIL press_latency got=%0d cycles expected=63..67", c);
        end
        n_cmp++;
        if ({evt_idx, evt_press, filtered} !== {2'd2, 1'b1, 4'b0100}) begin
            n_bad++;
            $display("FAIL press_event got idx=%0d press=%b filt=%b expected idx=2 press=1 filt=0100",
                     evt_idx, evt_press, filtered);
        end
        @(negedge clock);
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++; $display("FAIL press_one_cycle got=%b expected=0", evt_valid);
        end
        clear_all();
    endtask

    task automatic test_bounce();
        int seen;
        int c;
        wait_slot(3);
        raw_btn[1] = 1'b1;
        seen = 0;
        repeat (40) begin @(negedge clock); if (evt_valid === 1'b1) seen++; end
        raw_btn[1] = 1'b0;
        repeat (4) begin @(negedge clock); if (evt_valid === 1'b1) seen++; end
        raw_btn[1] = 1'b1;
        c = 0;
        while (evt_valid !== 1'b1 && c < 120) begin @(negedge clock); c++; end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL bounce_no_early got=%0d events expected=0", seen);
        end
        n_cmp++;
        if (c != 63 || evt_idx !== 2'd1 || evt_press !== 1'b1) begin
            n_bad++;
            $display("FAIL bounce_commit got c=%0d idx=%0d press=%b expected c=63 idx=1 press=1",
                     c, evt_idx, evt_press);
        end
        wait_slot(3);
        raw_btn[1] = 1'b0;
        c = 0;
        while (evt_valid !== 1'b1 && c < 120) begin @(negedge clock); c++; end
        n_cmp++;
        if (c != 63 || evt_idx !== 2'd1 || evt_press !== 1'b0 || filtered[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL release_commit got c=%0d idx=%0d press=%b expected c=63 idx=1 press=0",
                     c, evt_idx, evt_press);
        end
        clear_all();
    endtask

    task automatic test_simultaneous();
        int c;
        wait_slot(2);
        raw_btn = 4'b1001;
        c = 0;
        while (evt_valid !== 1'b1 && c < 100) begin @(negedge clock); c++; end
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_idx !== 2'd0 || evt_press !== 1'b1) begin
            n_bad++; $display("FAIL simul_first got vld=%b idx=%0d expected vld=1 idx=0", evt_valid, evt_idx);
        end
        c = 0;
        do begin @(negedge clock); c++; end while (evt_valid !== 1'b1 && c < 10);
        n_cmp++;
        if (c != 3 || evt_idx !== 2'd3 || evt_press !== 1'b1) begin
            n_bad++; $display("FAIL simul_second got gap=%0d idx=%0d expected gap=3 idx=3", c, evt_idx);
        end
        clear_all();
    endtask

    task automatic test_back_pressure();
        int  c;
        int  s;
        bit  stable;
        evt_ready  = 1'b0;
        raw_btn[2] = 1'b1;
        repeat (20) @(negedge clock);
        raw_btn[0] = 1'b1;
        c = 0;
        while (evt_valid !== 1'b1 && c < 100) begin @(negedge clock); c++; end
        s = int'(scan_idx);
        stable = (evt_valid === 1'b1);
        repeat (20) begin
            @(negedge clock);
            if (evt_valid !== 1'b1 || scan_idx !== IW'(s) || evt_idx !== 2'd2 ||
                evt_press !== 1'b1 || filtered !== 4'b0100) stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_bad++;
            $display("FAIL stall_frozen got vld=%b scan=%0d idx=%0d filt=%b expected vld=1 scan=%0d idx=2 filt=0100",
                     evt_valid, scan_idx, evt_idx, filtered, s);
        end
        evt_ready = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (evt_valid !== 1'b0 || scan_idx !== IW'((s + 1) % N)) begin
            n_bad++;
            $display("FAIL stall_release got vld=%b scan=%0d expected vld=0 scan=%0d",
                     evt_valid, scan_idx, (s + 1) % N);
        end
        clear_all();
    endtask

    task automatic test_enable_gating();
        int  n;
        int  k;
        bit  held;
        bit  early;
        wait_slot(2);
        raw_btn[0] = 1'b1;
        n = 0; k = 0;
        while (n < 8 && k < 100) begin
            @(negedge clock); k++;
            if (scan_idx === 2'd1) n++;
        end
        enable = 1'b0;
        held = 1'b1;
        repeat (50) begin
            @(negedge clock);
            if (filtered[0] !== 1'b0 || scan_idx !== 2'd1 || evt_valid !== 1'b0) held = 1'b0;
        end
        n_cmp++;
        if (!held) begin
            n_bad++; $display("FAIL enable_hold got filt=%b scan=%0d expected filt=0000 scan=1", filtered, scan_idx);
        end
        enable = 1'b1;
        n = 0; k = 0; early = 1'b0;
        while (n < 8 && k < 100) begin
            @(negedge clock); k++;
            if (scan_idx === 2'd1) begin
                n++;
                if (n < 8 && filtered[0] !== 1'b0) early = 1'b1;
            end
        end
        n_cmp++;
        if (early || evt_valid !== 1'b1 || evt_idx !== 2'd0 || filtered[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL enable_resume got early=%b vld=%b idx=%0d filt=%b expected early=0 vld=1 idx=0 filt0=1",
                     early, evt_valid, evt_idx, filtered);
        end
        clear_all();
    endtask

    task automatic test_random();
        int hold [N];
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 90);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock);
            reset = 1'b0;
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    raw_btn[i] = ~raw_btn[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6)
                                                           : $urandom_range(60, 120);
                end
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                #1;
                n_cmp++;
                if (dut_obs !== '0) begin
                    n_bad++; $display("FAIL random_reset got=%b expected=0", dut_obs);
                end
            end
        end
        @(negedge clock);
        reset = 1'b0;
        clear_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b1; evt_ready = 1'b1; raw_btn = '0;
        test_reset();
        test_steady_press();
        test_bounce();
        test_simultaneous();
        test_back_pressure();
        test_enable_gating();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
